lcd_cfg_queue: RTL and testbench

Second-generation AHB-lite configuration and command block for the HD44780 controller. It sits between the AHB-lite fabric and the LCD PHY, adding a parametrised instruction FIFO, a drain state machine that feeds the PHY one instruction at a time, latched read data, status and interrupt registers. Software can queue up to FIFO_DEPTH instructions without polling `phy_ready`.

---
 rtl/lcd_cfg_pkg.sv | 40 ++++
 rtl/lcd_instr_fifo.sv | 73 +++++++
 rtl/lcd_cfg_queue.sv | 193 +++++++++++++++++++
 tb/tb_lcd_cfg_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cfg_pkg.sv
`default_nettype none
// ============================================================================
// lcd_cfg_pkg : register map, response/issue state encodings, IRQ bit layout
// Rev 1.0
// ============================================================================
package lcd_cfg_pkg;

    localparam logic [4:0] LCD_CFG_CTRL      = 5'h00;
    localparam logic [4:0] LCD_CFG_INSTR     = 5'h04;
    localparam logic [4:0] LCD_CFG_RDATA     = 5'h08;
    localparam logic [4:0] LCD_CFG_PRESCALER = 5'h0C;
    localparam logic [4:0] LCD_CFG_STATUS    = 5'h10;
    localparam logic [4:0] LCD_CFG_IRQ       = 5'h14;
    localparam int unsigned LCD_CFG_MAX_OFFSET = 32'h18;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_READY_BIT  = 1;
    localparam int CTRL_FLUSH_BIT  = 2;
    localparam int CTRL_IRQ_EN_BIT = 3;

    localparam int IRQ_DRAINED   = 0;
    localparam int IRQ_RDATA_NEW = 1;
    localparam int IRQ_OVERFLOW  = 2;
    localparam int IRQ_W         = 3;

    // bit1 drives hready, bit0 drives hresp
    typedef enum logic [1:0] {
        OKAY   = 2'b10,
        ERROR1 = 2'b01,
        ERROR2 = 2'b11
    } resp_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        HOLD  = 2'b10
    } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_instr_fifo.sv
`default_nettype none
// ============================================================================
// lcd_instr_fifo : synchronous FIFO with flush; pop on empty is legal only
//                  when a push arrives in the same cycle (pass-through).
// Rev 1.0
// ============================================================================
module lcd_instr_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             w_do_push, w_do_pop;

    assign o_full    = (level_q == LW'(DEPTH));
    assign o_empty   = (level_q == '0);
    assign o_level   = level_q;
    assign o_head    = mem_q[rd_ptr_q];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & (~o_empty | w_do_push);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/lcd_cfg_queue.sv
`default_nettype none
// ============================================================================
// lcd_cfg_queue : AHB-lite register block with instruction FIFO feeding the
//                 HD44780 PHY through an IDLE/ISSUE/HOLD drain machine.
// Rev 1.0
// ============================================================================
module lcd_cfg_queue
    import lcd_cfg_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int INSTR_WIDTH     = 10,
    parameter int PRESCALER_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int ADDR_WIDTH      = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_WIDTH-1:0]      haddr_i,
    input  logic [31:0]                hwdata_i,
    input  logic                       hwrite_i,
    input  logic [1:0]                 htrans_i,
    output logic [31:0]                hrdata_o,
    output logic                       hready_out_o,
    output logic                       hresp_o,
    input  logic [DATA_WIDTH-1:0]      lcd_rdata_i,
    input  logic                       lcd_rdata_valid_i,
    input  logic                       phy_ready_i,
    output logic                       phy_enable_o,
    output logic [PRESCALER_WIDTH-1:0] prescaler_10ns_o,
    output logic [INSTR_WIDTH-1:0]     lcd_instr_o,
    output logic                       valid_instr_o,
    output logic                       irq_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    resp_state_e                resp_q, resp_d;
    issue_state_e               state_q, state_d;
    logic                       dvalid_q, dvalid_d, dwrite_q, dwrite_d;
    logic [4:0]                 daddr_q, daddr_d;
    logic                       phy_enable_q, phy_enable_d, irq_en_q, irq_en_d;
    logic [PRESCALER_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [INSTR_WIDTH-1:0]     last_instr_q, last_instr_d, lcd_instr_q, lcd_instr_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [IRQ_W-1:0]           irq_q, irq_d, w_irq_set, w_irq_clr;

    logic                       w_addr_sel, w_err_addr, w_err_ovf, w_err;
    logic                       w_wr, w_push, w_flush, w_pop, w_full_pend;
    logic [LVL_W-1:0]           w_level;
    logic                       w_full, w_empty;
    logic [INSTR_WIDTH-1:0]     w_head;
    logic                       w_unused;

    assign w_unused    = ^hwdata_i;
    assign w_addr_sel  = htrans_i[1] & hready_out_o;
    assign w_wr        = dvalid_q & dwrite_q;
    assign w_push      = w_wr & (daddr_q == LCD_CFG_INSTR);
    assign w_flush     = w_wr & (daddr_q == LCD_CFG_CTRL) & hwdata_i[CTRL_FLUSH_BIT];
    // A push completing this cycle counts as occupied; a concurrent pop does not help.
    assign w_full_pend = w_full | (w_push & (w_level == LVL_W'(FIFO_DEPTH - 1)));
    assign w_err_addr  = (haddr_i >= ADDR_WIDTH'(LCD_CFG_MAX_OFFSET)) | (haddr_i[1:0] != 2'b00);
    assign w_err_ovf   = hwrite_i & (haddr_i == ADDR_WIDTH'(LCD_CFG_INSTR)) & w_full_pend;
    assign w_err       = w_addr_sel & (w_err_addr | w_err_ovf);

    lcd_instr_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (w_push),
        .i_push_data (hwdata_i[INSTR_WIDTH-1:0]),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        resp_d       = OKAY;
        dvalid_d     = w_addr_sel & ~w_err;
        dwrite_d     = hwrite_i;
        daddr_d      = haddr_i[4:0];
        phy_enable_d = phy_enable_q;
        irq_en_d     = irq_en_q;
        prescaler_d  = prescaler_q;
        last_instr_d = last_instr_q;
        rdata_d      = rdata_q;
        w_irq_clr    = '0;
        w_irq_set    = '0;
        state_d      = state_q;
        lcd_instr_d  = lcd_instr_q;
        w_pop        = 1'b0;

        if (resp_q == ERROR1)  resp_d = ERROR2;
        else if (w_err)        resp_d = ERROR1;

        if (w_wr) begin
            case (daddr_q)
                LCD_CFG_CTRL: begin
                    phy_enable_d = hwdata_i[CTRL_ENABLE_BIT];
                    irq_en_d     = hwdata_i[CTRL_IRQ_EN_BIT];
                end
                LCD_CFG_INSTR:     last_instr_d = hwdata_i[INSTR_WIDTH-1:0];
                LCD_CFG_PRESCALER: prescaler_d  = hwdata_i[PRESCALER_WIDTH-1:0];
                LCD_CFG_IRQ:       w_irq_clr    = hwdata_i[IRQ_W-1:0];
                default:           ;
            endcase
        end

        if (lcd_rdata_valid_i) rdata_d = lcd_rdata_i;

        // An empty FIFO with a push landing now forwards the write data straight out.
        case (state_q)
            IDLE: begin
                if (phy_enable_q && phy_ready_i && (!w_empty || w_push)) begin
                    state_d     = ISSUE;
                    w_pop       = 1'b1;
                    lcd_instr_d = w_empty ? hwdata_i[INSTR_WIDTH-1:0] : w_head;
                end
            end
            ISSUE:   state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        w_irq_set[IRQ_DRAINED]   = w_pop & ~w_push & ~w_flush & (w_level == LVL_W'(1));
        w_irq_set[IRQ_RDATA_NEW] = lcd_rdata_valid_i;
        w_irq_set[IRQ_OVERFLOW]  = w_addr_sel & w_err_ovf;
        irq_d = (irq_q & ~w_irq_clr) | w_irq_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q       <= OKAY;
            state_q      <= IDLE;
            dvalid_q     <= 1'b0;
            dwrite_q     <= 1'b0;
            daddr_q      <= '0;
            phy_enable_q <= 1'b0;
            irq_en_q     <= 1'b0;
            prescaler_q  <= PRESCALER_WIDTH'(10);
            last_instr_q <= '0;
            lcd_instr_q  <= '0;
            rdata_q      <= '0;
            irq_q        <= '0;
        end else begin
            resp_q       <= resp_d;
            state_q      <= state_d;
            dvalid_q     <= dvalid_d;
            dwrite_q     <= dwrite_d;
            daddr_q      <= daddr_d;
            phy_enable_q <= phy_enable_d;
            irq_en_q     <= irq_en_d;
            prescaler_q  <= prescaler_d;
            last_instr_q <= last_instr_d;
            lcd_instr_q  <= lcd_instr_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        hrdata_o = '0;
        if (dvalid_q && !dwrite_q) begin
            case (daddr_q)
                LCD_CFG_CTRL: begin
                    hrdata_o[CTRL_ENABLE_BIT] = phy_enable_q;
                    hrdata_o[CTRL_READY_BIT]  = phy_ready_i;
                    hrdata_o[CTRL_IRQ_EN_BIT] = irq_en_q;
                end
                LCD_CFG_INSTR:     hrdata_o = 32'(last_instr_q);
                LCD_CFG_RDATA:     hrdata_o = 32'(rdata_q);
                LCD_CFG_PRESCALER: hrdata_o = 32'(prescaler_q);
                LCD_CFG_STATUS:    hrdata_o = {14'b0, w_full, w_empty, 16'(w_level)};
                LCD_CFG_IRQ:       hrdata_o = 32'(irq_q);
                default:           hrdata_o = '0;
            endcase
        end
    end

    assign hready_out_o     = resp_q[1];
    assign hresp_o          = resp_q[0];
    assign phy_enable_o     = phy_enable_q;
    assign prescaler_10ns_o = prescaler_q;
    assign lcd_instr_o      = lcd_instr_q;
    assign valid_instr_o    = (state_q == ISSUE);
    assign irq_o            = irq_en_q & (|irq_q);

endmodule
`default_nettype wire

// File: tb/tb_lcd_cfg_queue.sv
`default_nettype none
// ============================================================================
// tb_lcd_cfg_queue : directed AHB stimulus with an issue-order scoreboard
// Rev 1.0
// ============================================================================
module tb_lcd_cfg_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [11:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] hrdata_o;
    logic        hready_out_o, hresp_o;
    logic [7:0]  lcd_rdata;
    logic        lcd_rdata_valid;
    logic        phy_ready = 1'b1;
    logic        phy_enable_o;
    logic [15:0] prescaler_10ns_o;
    logic [9:0]  lcd_instr_o;
    logic        valid_instr_o, irq_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;

    lcd_cfg_queue #(
        .DATA_WIDTH(8), .INSTR_WIDTH(10), .PRESCALER_WIDTH(16),
        .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(12)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .haddr_i           (haddr),
        .hwdata_i          (hwdata),
        .hwrite_i          (hwrite),
        .htrans_i          (htrans),
        .hrdata_o          (hrdata_o),
        .hready_out_o      (hready_out_o),
        .hresp_o           (hresp_o),
        .lcd_rdata_i       (lcd_rdata),
        .lcd_rdata_valid_i (lcd_rdata_valid),
        .phy_ready_i       (phy_ready),
        .phy_enable_o      (phy_enable_o),
        .prescaler_10ns_o  (prescaler_10ns_o),
        .lcd_instr_o       (lcd_instr_o),
        .valid_instr_o     (valid_instr_o),
        .irq_o             (irq_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ahb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic [1:0] resp1, output logic [1:0] resp2);
        @(negedge clk);
        haddr  = addr;
        hwrite = wr;
        htrans = 2'b10;
        @(negedge clk);
        htrans = 2'b00;
        hwdata = wdata;
        resp1  = {hready_out_o, hresp_o};
        rdata  = hrdata_o;
        resp2  = resp1;
        if (!hready_out_o) begin
            @(negedge clk);
            resp2 = {hready_out_o, hresp_o};
        end
    endtask

    task automatic ahb_write(input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic [1:0]  r1, r2;
        ahb_xfer(1'b1, addr, wdata, rd, r1, r2);
        check_val($sformatf("wr_resp_%0h", addr), {30'b0, r1}, 32'h2);
    endtask

    task automatic ahb_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [1:0]  r1, r2;
        ahb_xfer(1'b0, addr, 32'h0, rd, r1, r2);
        check_val({tag, "_resp"}, {30'b0, r1}, 32'h2);
        check_val(tag, rd, exp);
    endtask

    task automatic ahb_err(input string tag, input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic [1:0]  r1, r2;
        ahb_xfer(wr, addr, wdata, rd, r1, r2);
        check_val({tag, "_err1"}, {30'b0, r1}, 32'h1);
        check_val({tag, "_err2"}, {30'b0, r2}, 32'h3);
        @(negedge clk);
        check_val({tag, "_okay"}, {30'b0, hready_out_o, hresp_o}, 32'h2);
    endtask

    task automatic push_instr(input logic [9:0] v);
        exp_q.push_back(v);
        ahb_write(12'h004, {22'b0, v});
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check_val("drain", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hrdata"}, hrdata_o, 32'h0);
        check_val({tag, "_resp"}, {30'b0, hready_out_o, hresp_o}, 32'h2);
        check_val({tag, "_enable"}, {31'b0, phy_enable_o}, 32'h0);
        check_val({tag, "_prescaler"}, {16'b0, prescaler_10ns_o}, 32'd10);
        check_val({tag, "_instr"}, {22'b0, lcd_instr_o}, 32'h0);
        check_val({tag, "_valid"}, {31'b0, valid_instr_o}, 32'h0);
        check_val({tag, "_irq"}, {31'b0, irq_o}, 32'h0);
    endtask

    // PHY model and issue scoreboard: busy for 5 cycles after every issue strobe
    initial begin
        int busy = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                busy      = 0;
                phy_ready = 1'b1;
            end else if (valid_instr_o) begin
                if (exp_q.size() == 0)
                    check_val("spurious_issue", {31'b0, valid_instr_o}, 32'h0);
                else
                    check_val("issue_order", {22'b0, lcd_instr_o}, {22'b0, exp_q.pop_front()});
                phy_ready = 1'b0;
                busy      = 5;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) phy_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t reached, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] rd;
        logic [1:0]  r1, r2;

        rst_i = 1'b1; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
        lcd_rdata = '0; lcd_rdata_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_i = 1'b0;

        ahb_read("rd_prescaler", 12'h00C, 32'h0000000A);
        ahb_read("rd_ctrl", 12'h000, 32'h00000002);
        ahb_read("rd_status", 12'h010, 32'h00010000);

        // queue three with issue disabled, then drain
        push_instr(10'h030);
        push_instr(10'h038);
        push_instr(10'h001);
        ahb_read("status_lvl3", 12'h010, 32'h00000003);
        ahb_read("rd_instr", 12'h004, 32'h00000001);
        ahb_write(12'h000, 32'h9);
        wait_drain(100);
        repeat (8) @(negedge clk);
        ahb_read("irq_drained", 12'h014, 32'h00000001);
        check_val("irq_on_drain", {31'b0, irq_o}, 32'h1);
        ahb_write(12'h014, 32'h1);
        @(negedge clk);
        check_val("irq_w1c", {31'b0, irq_o}, 32'h0);

        // empty FIFO + ready PHY: issue in cycle N+2
        push_instr(10'h0C5);
        @(negedge clk);
        check_val("bypass_latency", {31'b0, valid_instr_o}, 32'h1);
        wait_drain(20);
        repeat (8) @(negedge clk);
        ahb_write(12'h014, 32'h7);

        // overflow and flush
        ahb_write(12'h000, 32'h8);
        for (int i = 0; i < DEPTH; i++) ahb_write(12'h004, 32'h100 + i);
        ahb_err("ovf", 1'b1, 12'h004, 32'h3FF);
        ahb_read("status_full", 12'h010, 32'h00020008);
        ahb_read("instr_not_overwritten", 12'h004, 32'h00000100 + DEPTH - 1);
        ahb_read("irq_overflow", 12'h014, 32'h00000004);
        check_val("irq_on_ovf", {31'b0, irq_o}, 32'h1);
        ahb_write(12'h000, 32'hC);
        ahb_read("status_flushed", 12'h010, 32'h00010000);
        ahb_read("ctrl_flush_rd0", 12'h000, 32'h0000000A);
        ahb_write(12'h014, 32'h4);
        @(negedge clk);
        check_val("irq_ovf_clr", {31'b0, irq_o}, 32'h0);

        // bad addresses
        ahb_err("oob_read", 1'b0, 12'h018, 32'h0);
        ahb_err("misalign_wr", 1'b1, 12'h006, 32'hFFFFFFFF);
        ahb_read("prescaler_kept", 12'h00C, 32'h0000000A);
        ahb_read("ctrl_kept", 12'h000, 32'h0000000A);
        ahb_write(12'h00C, 32'h1234);
        ahb_read("prescaler_rw", 12'h00C, 32'h00001234);

        // rdata capture, then W1C colliding with a new strobe
        @(negedge clk);
        lcd_rdata = 8'hA5; lcd_rdata_valid = 1'b1;
        @(negedge clk);
        lcd_rdata_valid = 1'b0;
        ahb_read("rdata", 12'h008, 32'h000000A5);
        ahb_read("irq_rdata_new", 12'h014, 32'h00000002);
        check_val("irq_on_rdata", {31'b0, irq_o}, 32'h1);
        ahb_xfer(1'b1, 12'h014, 32'h2, rd, r1, r2);
        lcd_rdata = 8'h5A; lcd_rdata_valid = 1'b1;
        @(negedge clk);
        lcd_rdata_valid = 1'b0;
        ahb_read("irq_set_wins", 12'h014, 32'h00000002);
        ahb_read("rdata2", 12'h008, 32'h0000005A);

        // reset while HOLD with entries queued
        for (int i = 0; i < 4; i++) push_instr(10'h040 + 10'(i));
        ahb_write(12'h000, 32'h1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid_instr_o && k < 50);
        check_val("wait_issue", {31'b0, valid_instr_o}, 32'h1);
        @(negedge clk);
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_i = 1'b0;
        repeat (12) @(negedge clk);
        check_val("no_issue_after_rst", {31'b0, valid_instr_o}, 32'h0);
        ahb_read("status_after_rst", 12'h010, 32'h00010000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
